kbd_rx_fifo: RTL and testbench

//  Keystroke receive buffer between the PS/2 decoder and the CPU bus/interrupt path.

---
 rtl/kbd_rx_fifo_if.sv | 24 ++
 rtl/kbd_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_kbd_rx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : kbd_rx_fifo_if
// Purpose  : CPU bus read path and interrupt handshake of the keyboard buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface kbd_rx_fifo_if;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic [3:0]  irq_vector;
    logic        irq_ack;

    modport master (
        output bus_address, bus_read_enable, irq_ack,
        input  bus_read_data, irq_vector
    );

    modport slave (
        input  bus_address, bus_read_enable, irq_ack,
        output bus_read_data, irq_vector
    );
endinterface
`default_nettype wire

// File: rtl/kbd_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kbd_rx_fifo
// Purpose  : Keystroke FIFO served at KEY_ADDR with a one-shot IRQ handshake.
//            Define KBD_STATUS_REG_EN to add the status register at KEY_ADDR+8.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_rx_fifo #(
    parameter int          DEPTH    = 16,
    parameter logic [63:0] KEY_ADDR = 64'h0000_8000,
    parameter logic [3:0]  IRQ_VEC  = 4'd1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    key_pressed_i,
    input  logic [7:0]              key_ascii_i,
    kbd_rx_fifo_if.slave            bus,
    output logic [$clog2(DEPTH):0]  fifo_count_o,
    output logic                    overflow_o
);
    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SERVED = 2'd2
    } irq_state_t;

    logic [7:0]   mem_q [DEPTH];
    logic [c_AW:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW:0] rd_ptr_q, rd_ptr_d;
    logic [63:0]  rd_data_q, rd_data_d;
    logic         overflow_q, overflow_d;
    logic         key_prev_q;
    logic         rd_prev_q;
    irq_state_t   irq_state_q;
    logic [3:0]   irq_vec_q;

    logic w_push, w_rd_sel, w_rd_edge, w_empty, w_full, w_wr_en, w_pop, w_st_edge;

    assign w_push    = key_pressed_i & ~key_prev_q & (key_ascii_i != 8'd0);
    assign w_rd_sel  = bus.bus_read_enable && (bus.bus_address == KEY_ADDR);
    assign w_rd_edge = w_rd_sel & ~rd_prev_q;
    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                       (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    // A pop in the same cycle does not make room for a push against a full FIFO.
    assign w_wr_en   = w_push & ~w_full;
    assign w_pop     = w_rd_edge & ~w_empty;

    assign fifo_count_o      = wr_ptr_q - rd_ptr_q;
    assign overflow_o        = overflow_q;
    assign bus.bus_read_data = rd_data_q;
    assign bus.irq_vector    = irq_vec_q;

`ifdef KBD_STATUS_REG_EN
    logic st_prev_q;
    logic w_st_sel;

    assign w_st_sel  = bus.bus_read_enable && (bus.bus_address == KEY_ADDR + 64'd8);
    assign w_st_edge = w_st_sel & ~st_prev_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st_prev_q <= 1'b0;
        end else begin
            st_prev_q <= w_st_sel;
        end
    end
`else
    assign w_st_edge = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q;
        if (w_wr_en) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        if (w_pop)   rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        if (w_rd_edge) begin
            rd_data_d = w_empty ? 64'd0 : {56'd0, mem_q[rd_ptr_q[c_AW-1:0]]};
        end else if (w_st_edge) begin
            rd_data_d = {overflow_q, 55'd0, 8'(fifo_count_o)};
        end
        // A drop in the same cycle as a status read wins over the clear.
        if (w_st_edge)         overflow_d = 1'b0;
        if (w_push && w_full)  overflow_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_wr_en) mem_q[wr_ptr_q[c_AW-1:0]] <= key_ascii_i;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= 64'd0;
            overflow_q <= 1'b0;
            key_prev_q <= 1'b0;
            rd_prev_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            key_prev_q <= key_pressed_i;
            rd_prev_q  <= w_rd_sel;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            irq_state_q <= IDLE;
            irq_vec_q   <= 4'd0;
        end else begin
            case (irq_state_q)
                IDLE: begin
                    if (!w_empty && !bus.irq_ack) begin
                        irq_state_q <= REQ;
                        irq_vec_q   <= IRQ_VEC;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        irq_state_q <= SERVED;
                        irq_vec_q   <= 4'd0;
                    end
                end
                SERVED: begin
                    if (w_empty && !bus.irq_ack) irq_state_q <= IDLE;
                end
                default: begin
                    irq_state_q <= IDLE;
                    irq_vec_q   <= 4'd0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_kbd_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_rx_fifo
// Purpose  : Directed and randomized self-checking bench for kbd_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_rx_fifo;
    localparam int          DEPTH    = 16;
    localparam logic [63:0] KEY_ADDR = 64'h0000_8000;
    localparam logic [3:0]  IRQ_VEC  = 4'd1;

    logic       CLOCK_50    = 1'b0;
    logic       reset       = 1'b1;
    logic       key_pressed = 1'b0;
    logic [7:0] key_ascii   = 8'd0;
    logic [4:0] fifo_count;
    logic       overflow;

    kbd_rx_fifo_if bus_if ();

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of stored codes, last read value, sticky drop flag.
    byte unsigned mq[$];
    logic [63:0]  m_data;
    bit           m_ovf;

    always #10 CLOCK_50 = ~CLOCK_50;

    kbd_rx_fifo #(
        .DEPTH    (DEPTH),
        .KEY_ADDR (KEY_ADDR),
        .IRQ_VEC  (IRQ_VEC)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .key_pressed_i (key_pressed),
        .key_ascii_i   (key_ascii),
        .bus           (bus_if.slave),
        .fifo_count_o  (fifo_count),
        .overflow_o    (overflow)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic apply_reset();
        reset                  = 1'b0;
        key_pressed            = 1'b0;
        key_ascii              = 8'd0;
        bus_if.bus_address     = 64'd0;
        bus_if.bus_read_enable = 1'b0;
        bus_if.irq_ack         = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        mq.delete();
        m_data = 64'd0;
        m_ovf  = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);
        key_ascii   = code;
        key_pressed = 1'b1;
        tick();
        key_pressed = 1'b0;
        tick();
        if (code != 8'd0) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else                    mq.push_back(code);
        end
    endtask

    task automatic bus_read(input logic [63:0] addr, input int hold);
        bus_if.bus_address     = addr;
        bus_if.bus_read_enable = 1'b1;
        repeat (hold) tick();
        bus_if.bus_read_enable = 1'b0;
        tick();
        bus_if.bus_address = 64'd0;
        if (addr == KEY_ADDR) begin
            m_data = (mq.size() != 0) ? {56'd0, mq.pop_front()} : 64'd0;
        end
`ifdef KBD_STATUS_REG_EN
        else if (addr == KEY_ADDR + 64'd8) begin
            m_data = {m_ovf, 55'd0, 8'(mq.size())};
            m_ovf  = 1'b0;
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_pressed            = 1'b0;
        bus_if.bus_address     = 64'd0;
        bus_if.bus_read_enable = 1'b0;
        bus_if.irq_ack         = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus_if.bus_read_data, bus_if.irq_vector, fifo_count, overflow} !== 74'd0) begin
            failures++;
            $display("FAIL reset_outputs: data=%0h irq=%0h count=%0d ovf=%0b required all zero",
                     bus_if.bus_read_data, bus_if.irq_vector, fifo_count, overflow);
        end
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus_if.irq_vector !== 4'd0) begin
            failures++;
            $display("FAIL reset_idle_irq: irq=%0h required 0", bus_if.irq_vector);
        end
        mq.delete();
        m_data = 64'd0;
        m_ovf  = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        key_ascii   = 8'h61;
        key_pressed = 1'b1;
        tick();
        checks++;
        if (fifo_count !== 5'd1 || bus_if.irq_vector !== 4'd0) begin
            failures++;
            $display("FAIL basic_push_latency: count=%0d irq=%0h required 1/0", fifo_count, bus_if.irq_vector);
        end
        key_pressed = 1'b0;
        tick();
        mq.push_back(8'h61);
        checks++;
        if (bus_if.irq_vector !== IRQ_VEC) begin
            failures++;
            $display("FAIL basic_irq_raise: irq=%0h required %0h", bus_if.irq_vector, IRQ_VEC);
        end
        press(8'h62);
        bus_read(KEY_ADDR, 10);
        checks++;
        if (bus_if.bus_read_data !== 64'h61 || fifo_count !== 5'd1) begin
            failures++;
            $display("FAIL basic_read_a: data=%0h count=%0d required 61/1", bus_if.bus_read_data, fifo_count);
        end
        bus_read(KEY_ADDR, 3);
        checks++;
        if (bus_if.bus_read_data !== 64'h62) begin
            failures++;
            $display("FAIL basic_read_b: data=%0h required 62", bus_if.bus_read_data);
        end
        bus_read(KEY_ADDR, 2);
        checks++;
        if (bus_if.bus_read_data !== 64'h0 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL basic_read_empty: data=%0h count=%0d required 0/0", bus_if.bus_read_data, fifo_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 17; i++) press(8'h41 + 8'(i));
        checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_fill: count=%0d ovf=%0b required 16/1", fifo_count, overflow);
        end
`ifdef KBD_STATUS_REG_EN
        bus_read(KEY_ADDR + 64'd8, 4);
        checks++;
        if (bus_if.bus_read_data !== 64'h8000_0000_0000_0010) begin
            failures++;
            $display("FAIL status_first: data=%0h required 8000000000000010", bus_if.bus_read_data);
        end
        bus_read(KEY_ADDR + 64'd8, 2);
        checks++;
        if (bus_if.bus_read_data !== 64'h0000_0000_0000_0010 || overflow !== 1'b0 || fifo_count !== 5'd16) begin
            failures++;
            $display("FAIL status_second: data=%0h ovf=%0b count=%0d required 10/0/16",
                     bus_if.bus_read_data, overflow, fifo_count);
        end
`endif
        for (int i = 0; i < 16; i++) begin
            bus_read(KEY_ADDR, 1 + (i % 3));
            checks++;
            if (bus_if.bus_read_data !== 64'(8'h41 + 8'(i))) begin
                failures++;
                $display("FAIL ovf_drain_%0d: data=%0h required %0h", i, bus_if.bus_read_data, 8'h41 + 8'(i));
            end
        end
        bus_read(KEY_ADDR, 1);
        checks++;
        if (bus_if.bus_read_data !== 64'd0 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL ovf_lost_entry: data=%0h count=%0d required 0/0", bus_if.bus_read_data, fifo_count);
        end
        press(8'h55);
        reset = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 5'd0 || bus_if.irq_vector !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop: count=%0d irq=%0h ovf=%0b required 0/0/0",
                     fifo_count, bus_if.irq_vector, overflow);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_irq();
        apply_reset();
        press(8'h70);
        checks++;
        if (bus_if.irq_vector !== IRQ_VEC) begin
            failures++;
            $display("FAIL irq_req: irq=%0h required %0h", bus_if.irq_vector, IRQ_VEC);
        end
        bus_if.irq_ack = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus_if.irq_vector !== 4'd0) begin
            failures++;
            $display("FAIL irq_acked: irq=%0h required 0", bus_if.irq_vector);
        end
        press(8'h71);
        tick();
        checks++;
        if (bus_if.irq_vector !== 4'd0 || fifo_count !== 5'd2) begin
            failures++;
            $display("FAIL irq_served_push: irq=%0h count=%0d required 0/2", bus_if.irq_vector, fifo_count);
        end
        bus_read(KEY_ADDR, 2);
        bus_read(KEY_ADDR, 2);
        checks++;
        if (bus_if.bus_read_data !== 64'h71 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL irq_drain: data=%0h count=%0d required 71/0", bus_if.bus_read_data, fifo_count);
        end
        bus_if.irq_ack = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus_if.irq_vector !== 4'd0) begin
            failures++;
            $display("FAIL irq_idle: irq=%0h required 0", bus_if.irq_vector);
        end
        press(8'h72);
        checks++;
        if (bus_if.irq_vector !== IRQ_VEC) begin
            failures++;
            $display("FAIL irq_rearm: irq=%0h required %0h", bus_if.irq_vector, IRQ_VEC);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus_if.bus_address     = KEY_ADDR;
        bus_if.bus_read_enable = 1'b1;
        key_ascii              = 8'h31;
        key_pressed            = 1'b1;
        tick();
        checks++;
        if (bus_if.bus_read_data !== 64'd0 || fifo_count !== 5'd1) begin
            failures++;
            $display("FAIL simul_empty: data=%0h count=%0d required 0/1", bus_if.bus_read_data, fifo_count);
        end
        bus_if.bus_read_enable = 1'b0;
        key_pressed            = 1'b0;
        tick();
        bus_if.bus_read_enable = 1'b1;
        key_ascii              = 8'h32;
        key_pressed            = 1'b1;
        tick();
        checks++;
        if (bus_if.bus_read_data !== 64'h31 || fifo_count !== 5'd1) begin
            failures++;
            $display("FAIL simul_one: data=%0h count=%0d required 31/1", bus_if.bus_read_data, fifo_count);
        end
        bus_if.bus_read_enable = 1'b0;
        key_pressed            = 1'b0;
        tick();
        bus_read(KEY_ADDR, 1);
        checks++;
        if (bus_if.bus_read_data !== 64'h32) begin
            failures++;
            $display("FAIL simul_follow: data=%0h required 32", bus_if.bus_read_data);
        end
    endtask

    task automatic test_random();
        int op;
        logic [7:0] code;
        apply_reset();
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                code = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                press(code);
            end else if (op < 8) begin
                bus_read(KEY_ADDR, $urandom_range(1, 4));
            end else if (op == 8) begin
                bus_read(64'h0000_1234 + 64'($urandom_range(0, 15)), 2);
            end else begin
                bus_read(KEY_ADDR + 64'd8, $urandom_range(1, 3));
            end
            checks++;
            if (bus_if.bus_read_data !== m_data || fifo_count !== 5'(mq.size()) || overflow !== m_ovf) begin
                failures++;
                $display("FAIL random_op_%0d: data=%0h count=%0d ovf=%0b required %0h/%0d/%0b",
                         n, bus_if.bus_read_data, fifo_count, overflow, m_data, mq.size(), m_ovf);
            end
        end
    endtask

    initial begin
        bus_if.bus_address     = 64'd0;
        bus_if.bus_read_enable = 1'b0;
        bus_if.irq_ack         = 1'b0;
        #5;
        test_reset();
        test_basic();
        test_overflow();
        test_irq();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
